// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the pipeline
// writeback stage and a FIFO-buffered secondary requester.
//   clk, rst (async, active-low)
//   p_we/p_vsel/p_addr/p_data     pipeline writeback (always wins, never held off)
//   s_valid/s_ready/s_vsel/s_addr/s_data  secondary write request (valid/ready)
//   rd_vsel/rd_a1/rd_a2, hazard_o decode RAW interlock
//   stall_o                       registered starvation stall to the pipeline
//   we_o/vsel_o/addr_o/data_o     registered register-file write port
// Optional: define REGFILE_WB_ARB_BYPASS_EN so that a secondary write can go
// straight to the output stage when the FIFO is empty and the pipeline is idle.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_we,
  input  logic              p_vsel,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_vsel,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              rd_vsel,
  input  logic [ADDR_W-1:0] rd_a1,
  input  logic [ADDR_W-1:0] rd_a2,
  output logic              hazard_o,
  output logic              stall_o,
  output logic              we_o,
  output logic              vsel_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [DEPTH-1:0]  vsel_mem_q;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              stall_q, stall_d;
  logic              we_q, we_d, vsel_q, vsel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              empty, acc, byp, push, pop, starved;
  logic [DEPTH-1:0]  ent_hit;

  function automatic logic hit(input logic v, input logic [ADDR_W-1:0] a,
                               input logic rv, input logic [ADDR_W-1:0] r1,
                               input logic [ADDR_W-1:0] r2);
    // scalar register 0 is hardwired, so a write to it can never be a RAW source
    return (v == rv) && ((a == r1) || (a == r2)) && (v || (a != '0));
  endfunction

  assign empty   = (count_q == '0);
  assign s_ready = (count_q != CW'(DEPTH));
  assign acc     = s_valid & s_ready;
`ifdef REGFILE_WB_ARB_BYPASS_EN
  assign byp     = acc & empty & ~p_we;
`else
  assign byp     = 1'b0;
`endif
  assign push    = acc & ~byp;
  assign pop     = ~p_we & ~empty;
  assign starved = (starve_q == SW'(STARVE_MAX));

  always_comb begin
    we_d     = p_we | pop | byp;
    vsel_d   = p_we ? p_vsel : pop ? vsel_mem_q[rd_ptr_q] : s_vsel;
    addr_d   = p_we ? p_addr : pop ? addr_mem_q[rd_ptr_q] : s_addr;
    data_d   = p_we ? p_data : pop ? data_mem_q[rd_ptr_q] : s_data;
    count_d  = count_q + CW'(push) - CW'(pop);
    starve_d = (empty | pop) ? '0 : starved ? starve_q : starve_q + SW'(1);
    stall_d  = pop ? 1'b0 : starved ? 1'b1 : stall_q;
  end

  // an entry is live when its distance from the read pointer is below count
  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    assign ent_hit[g] = ({1'b0, PW'(g) - rd_ptr_q} < count_q) &&
                        hit(vsel_mem_q[g], addr_mem_q[g], rd_vsel, rd_a1, rd_a2);
  end
  assign hazard_o = (|ent_hit) | (we_q & hit(vsel_q, addr_q, rd_vsel, rd_a1, rd_a2));

  always_ff @(posedge clk) begin
    if (push) begin
      vsel_mem_q[wr_ptr_q] <= s_vsel;
      addr_mem_q[wr_ptr_q] <= s_addr;
      data_mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      vsel_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      vsel_q   <= vsel_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign stall_o = stall_q;
  assign we_o    = we_q;
  assign vsel_o  = vsel_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  localparam int DW = 256;
  localparam int AW = 5;

  logic          clk = 1'b0, rst = 1'b0;
  logic          p_we = 1'b0, p_vsel = 1'b0, s_valid = 1'b0, s_vsel = 1'b0, rd_vsel = 1'b0;
  logic [AW-1:0] p_addr = '0, s_addr = '0, rd_a1 = '0, rd_a2 = '0;
  logic [DW-1:0] p_data = '0, s_data = '0;
  logic          s_ready, hazard_o, stall_o, we_o, vsel_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  int            n_cmp = 0, n_err = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .p_we(p_we), .p_vsel(p_vsel), .p_addr(p_addr), .p_data(p_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_vsel(s_vsel), .s_addr(s_addr), .s_data(s_data),
    .rd_vsel(rd_vsel), .rd_a1(rd_a1), .rd_a2(rd_a2),
    .hazard_o(hazard_o), .stall_o(stall_o),
    .we_o(we_o), .vsel_o(vsel_o), .addr_o(addr_o), .data_o(data_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({we_o, vsel_o, addr_o, data_o, stall_o, s_ready} !== {1'b0, 1'b0, 5'd0, 256'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_init: we=%b vsel=%b addr=%0d data=%h stall=%b s_ready=%b, want 0/0/0/0/0/1",
               we_o, vsel_o, addr_o, data_o, stall_o, s_ready);
    end
    rst = 1'b1;
    tick();
    p_we = 1'b1; p_vsel = 1'b0; p_addr = 5'd1; p_data = 256'd1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_vsel = 1'b1; s_addr = AW'(20 + i); s_data = DW'(100 + i);
      tick();
    end
    s_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({we_o, vsel_o, addr_o, data_o, stall_o, s_ready} !== {1'b0, 1'b0, 5'd0, 256'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_mid: we=%b vsel=%b addr=%0d data=%h stall=%b s_ready=%b, want 0/0/0/0/0/1",
               we_o, vsel_o, addr_o, data_o, stall_o, s_ready);
    end
    p_we = 1'b0;
    tick();
    #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (we_o !== 1'b0) begin
        n_err++;
        $display("FAIL reset_discard cycle %0d: we=%b addr=%0d, want we=0", i, we_o, addr_o);
      end
    end
  endtask

  task automatic test_pipeline;
    p_we = 1'b1; p_vsel = 1'b0; p_addr = 5'd5; p_data = 256'hA5;
    tick();
    n_cmp++;
    if ({we_o, vsel_o, addr_o, data_o} !== {1'b1, 1'b0, 5'd5, 256'hA5}) begin
      n_err++;
      $display("FAIL pipe_write: we=%b vsel=%b addr=%0d data=%h, want 1/0/5/a5", we_o, vsel_o, addr_o, data_o);
    end
    p_we = 1'b0;
    tick();
    n_cmp++;
    if (we_o !== 1'b0) begin
      n_err++;
      $display("FAIL pipe_single_cycle: we=%b, want 0", we_o);
    end
  endtask

  task automatic test_order;
    p_we = 1'b1; p_vsel = 1'b0; p_addr = 5'd2; p_data = 256'd0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_vsel = 1'b1; s_addr = AW'(i + 1); s_data = DW'(1000 + i);
      tick();
    end
    s_valid = 1'b0; p_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({we_o, vsel_o, addr_o, data_o} !== {1'b1, 1'b1, AW'(i + 1), DW'(1000 + i)}) begin
        n_err++;
        $display("FAIL order_%0d: we=%b vsel=%b addr=%0d data=%0d, want 1/1/%0d/%0d",
                 i, we_o, vsel_o, addr_o, data_o, i + 1, 1000 + i);
      end
    end
    tick();
    n_cmp++;
    if (we_o !== 1'b0) begin
      n_err++;
      $display("FAIL order_drained: we=%b, want 0", we_o);
    end
  endtask

  task automatic test_full_starve;
    p_we = 1'b1; p_vsel = 1'b0; p_addr = 5'd1; p_data = 256'd7;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_vsel = 1'b0; s_addr = AW'(10 + i); s_data = DW'(200 + i);
      n_cmp++;
      if (s_ready !== 1'b1) begin
        n_err++;
        $display("FAIL fill_ready_%0d: s_ready=%b, want 1", i, s_ready);
      end
      tick();
    end
    s_addr = 5'd14; s_data = 256'd204;
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ready: s_ready=%b, want 0", s_ready);
    end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if ({stall_o, we_o, addr_o, data_o} !== {1'b0, 1'b1, 5'd1, 256'd7}) begin
      n_err++;
      $display("FAIL starve_pre: stall=%b we=%b addr=%0d data=%0d, want 0/1/1/7", stall_o, we_o, addr_o, data_o);
    end
    tick();
    n_cmp++;
    if (stall_o !== 1'b1) begin
      n_err++;
      $display("FAIL starve_stall: stall=%b, want 1", stall_o);
    end
    p_we = 1'b0;
    tick();
    n_cmp++;
    if ({stall_o, we_o, vsel_o, addr_o, data_o} !== {1'b0, 1'b1, 1'b0, 5'd10, 256'd200}) begin
      n_err++;
      $display("FAIL starve_release: stall=%b we=%b addr=%0d data=%0d, want 0/1/10/200",
               stall_o, we_o, addr_o, data_o);
    end
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL freed_ready: s_ready=%b, want 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    n_cmp++;
    if ({we_o, addr_o, data_o} !== {1'b1, 5'd11, 256'd201}) begin
      n_err++;
      $display("FAIL drain_1: we=%b addr=%0d data=%0d, want 1/11/201", we_o, addr_o, data_o);
    end
    for (int i = 2; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({we_o, addr_o, data_o} !== {1'b1, AW'(10 + i), DW'(200 + i)}) begin
        n_err++;
        $display("FAIL drain_%0d: we=%b addr=%0d data=%0d, want 1/%0d/%0d", i, we_o, addr_o, data_o, 10 + i, 200 + i);
      end
    end
    tick();
    n_cmp++;
    if ({we_o, stall_o} !== 2'b00) begin
      n_err++;
      $display("FAIL drain_done: we=%b stall=%b, want 0/0", we_o, stall_o);
    end
  endtask

  task automatic test_hazard;
    p_we = 1'b1; p_vsel = 1'b0; p_addr = 5'd0; p_data = 256'd3;
    s_valid = 1'b1; s_vsel = 1'b1; s_addr = 5'd7; s_data = 256'd77;
    tick();
    s_valid = 1'b0;
    rd_vsel = 1'b1; rd_a1 = 5'd2; rd_a2 = 5'd7;
    #1;
    n_cmp++;
    if (hazard_o !== 1'b1) begin
      n_err++;
      $display("FAIL hazard_vec_queued: hazard=%b, want 1", hazard_o);
    end
    rd_vsel = 1'b0;
    #1;
    n_cmp++;
    if (hazard_o !== 1'b0) begin
      n_err++;
      $display("FAIL hazard_wrong_file: hazard=%b, want 0", hazard_o);
    end
    rd_a1 = 5'd0; rd_a2 = 5'd0;
    #1;
    n_cmp++;
    if (hazard_o !== 1'b0) begin
      n_err++;
      $display("FAIL hazard_scalar_zero: hazard=%b, want 0", hazard_o);
    end
    rd_vsel = 1'b1; rd_a1 = 5'd2; rd_a2 = 5'd7;
    p_we = 1'b0;
    tick();
    n_cmp++;
    if ({hazard_o, we_o, vsel_o, addr_o} !== {1'b1, 1'b1, 1'b1, 5'd7}) begin
      n_err++;
      $display("FAIL hazard_out_stage: hazard=%b we=%b vsel=%b addr=%0d, want 1/1/1/7", hazard_o, we_o, vsel_o, addr_o);
    end
    tick();
    n_cmp++;
    if ({hazard_o, we_o} !== 2'b00) begin
      n_err++;
      $display("FAIL hazard_drop: hazard=%b we=%b, want 0/0", hazard_o, we_o);
    end
    rd_vsel = 1'b0; rd_a1 = '0; rd_a2 = '0;
  endtask

  task automatic test_bypass;
    p_we = 1'b0;
    s_valid = 1'b1; s_vsel = 1'b0; s_addr = 5'd9; s_data = 256'd99;
    tick();
    s_valid = 1'b0;
`ifdef REGFILE_WB_ARB_BYPASS_EN
    n_cmp++;
    if ({we_o, addr_o, data_o} !== {1'b1, 5'd9, 256'd99}) begin
      n_err++;
      $display("FAIL bypass_t1: we=%b addr=%0d data=%0d, want 1/9/99", we_o, addr_o, data_o);
    end
    tick();
    n_cmp++;
    if (we_o !== 1'b0) begin
      n_err++;
      $display("FAIL bypass_t2: we=%b, want 0", we_o);
    end
`else
    n_cmp++;
    if (we_o !== 1'b0) begin
      n_err++;
      $display("FAIL fifo_t1: we=%b, want 0", we_o);
    end
    tick();
    n_cmp++;
    if ({we_o, addr_o, data_o} !== {1'b1, 5'd9, 256'd99}) begin
      n_err++;
      $display("FAIL fifo_t2: we=%b addr=%0d data=%0d, want 1/9/99", we_o, addr_o, data_o);
    end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_order();
    test_full_starve();
    test_hazard();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within 100000 time units");
    $fatal(1);
  end
endmodule
